// File: rtl/apb_master_ctrl.sv
// APB4 master: one outstanding command, address-decoded slave select,
// wait-state handling with an optional timeout, and a held response channel.
module apb_master_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int NSLV    = 4,
    parameter int SEL_LSB = 12,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [ADDR_W-1:0]        cmd_addr,
    input  logic [DATA_W-1:0]        cmd_wdata,
    input  logic [DATA_W/8-1:0]      cmd_strb,
    input  logic [2:0]               cmd_prot,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic [NSLV-1:0]          psel,
    output logic                     penable,
    output logic                     pwrite,
    output logic [ADDR_W-1:0]        paddr,
    output logic [DATA_W-1:0]        pwdata,
    output logic [DATA_W/8-1:0]      pstrb,
    output logic [2:0]               pprot,
    input  logic [NSLV*DATA_W-1:0]   prdata,
    input  logic [NSLV-1:0]          pready,
    input  logic [NSLV-1:0]          pslverr
);

    localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int SB = DATA_W / 8;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

    state_e            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [NSLV-1:0]   psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [SB-1:0]     pstrb_q, pstrb_d;
    logic [2:0]        pprot_q, pprot_d;
    logic [SW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     wait_cnt_q, wait_cnt_d;

    logic [SW-1:0]     cmd_idx;
    logic              decode_err;
    logic              sel_ready;
    logic              sel_err;
    logic [DATA_W-1:0] sel_rdata;

    assign cmd_idx    = cmd_addr[SEL_LSB +: SW];
    assign decode_err = {1'b0, cmd_idx} >= (SW + 1)'(NSLV);

    // Only the selected slave's response lines are ever looked at.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (idx_q == SW'(i)) begin
                sel_ready = pready[i];
                sel_err   = pslverr[i];
                sel_rdata = prdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        // NOTE: every _d starts as its _q so no path leaves a variable unassigned (no latches).
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        pprot_d     = pprot_q;
        idx_d       = idx_q;
        wait_cnt_d  = wait_cnt_q;

        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    if (decode_err) begin
                        // Unmapped target: answer immediately, APB outputs untouched.
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                        state_d     = RESP;
                    end else begin
                        idx_d      = cmd_idx;
                        pwrite_d   = cmd_write;
                        paddr_d    = cmd_addr;
                        pwdata_d   = cmd_write ? cmd_wdata : '0;
                        pstrb_d    = cmd_write ? cmd_strb : '0;
                        pprot_d    = cmd_prot;
                        wait_cnt_d = '0;
                        for (int i = 0; i < NSLV; i++) begin
                            psel_d[i] = (cmd_idx == SW'(i));
                        end
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (sel_ready) begin
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = sel_err;
                    rsp_rdata_d = pwrite_q ? '0 : sel_rdata;
                    state_d     = RESP;
                end else if (TIMEOUT != 0 && wait_cnt_q == TO_LAST) begin
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            pprot_q     <= '0;
            idx_q       <= '0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            pprot_q     <= pprot_d;
            idx_q       <= idx_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign pstrb     = pstrb_q;
    assign pprot     = pprot_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl with three slaves (slave index 3 is unmapped)
// and a 16-cycle wait-state timeout.
module tb_apb_master_ctrl;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int NSLV    = 3;
    localparam int SEL_LSB = 12;
    localparam int TIMEOUT = 16;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic                   cmd_write;
    logic [ADDR_W-1:0]      cmd_addr;
    logic [DATA_W-1:0]      cmd_wdata;
    logic [DATA_W/8-1:0]    cmd_strb;
    logic [2:0]             cmd_prot;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [DATA_W-1:0]      rsp_rdata;
    logic                   rsp_err;
    logic [NSLV-1:0]        psel;
    logic                   penable;
    logic                   pwrite;
    logic [ADDR_W-1:0]      paddr;
    logic [DATA_W-1:0]      pwdata;
    logic [DATA_W/8-1:0]    pstrb;
    logic [2:0]             pprot;
    logic [NSLV*DATA_W-1:0] prdata;
    logic [NSLV-1:0]        pready;
    logic [NSLV-1:0]        pslverr;
    logic [DATA_W-1:0]      slv_rdata [NSLV];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign prdata = {slv_rdata[2], slv_rdata[1], slv_rdata[0]};

    apb_master_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NSLV   (NSLV),
        .SEL_LSB(SEL_LSB),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .cmd_strb (cmd_strb),
        .cmd_prot (cmd_prot),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .pstrb    (pstrb),
        .pprot    (pprot),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] strb, input logic [2:0] prot);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        cmd_strb  = strb;
        cmd_prot  = prot;
        step();
        cmd_valid = 1'b0;
        cmd_wdata = 32'h0;
        cmd_strb  = 4'h0;
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        cmd_prot  = '0;
        rsp_ready = 1'b1;
        pready    = '0;
        pslverr   = '0;
        for (int i = 0; i < NSLV; i++) slv_rdata[i] = '0;

        // Reset state
        step();
        check("rst_cmd_ready", 32'(cmd_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_psel", 32'(psel), 32'h0);
        check("rst_penable", 32'(penable), 32'h0);
        check("rst_paddr", paddr, 32'h0);
        check("rst_pwdata", pwdata, 32'h0);
        rst = 1'b0;
        step();
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'h1);

        // Zero-wait read from slave 0; slave 1 raises error and ready but is not selected
        pready       = 3'b011;
        pslverr      = 3'b010;
        slv_rdata[0] = 32'hDEADBEEF;
        slv_rdata[1] = 32'h11111111;
        issue(1'b0, 32'h0000_0004, 32'hFFFF_FFFF, 4'hF, 3'b010);
        check("rd_setup_psel", 32'(psel), 32'h1);
        check("rd_setup_penable", 32'(penable), 32'h0);
        check("rd_setup_paddr", paddr, 32'h4);
        check("rd_setup_pwrite", 32'(pwrite), 32'h0);
        check("rd_setup_pwdata", pwdata, 32'h0);
        check("rd_setup_pstrb", 32'(pstrb), 32'h0);
        check("rd_setup_pprot", 32'(pprot), 32'h2);
        check("rd_setup_cmd_ready", 32'(cmd_ready), 32'h0);
        step();
        check("rd_access_psel", 32'(psel), 32'h1);
        check("rd_access_penable", 32'(penable), 32'h1);
        check("rd_access_rsp_valid", 32'(rsp_valid), 32'h0);
        step();
        check("rd_resp_valid", 32'(rsp_valid), 32'h1);
        check("rd_resp_rdata", rsp_rdata, 32'hDEADBEEF);
        check("rd_resp_err", 32'(rsp_err), 32'h0);
        check("rd_resp_psel", 32'(psel), 32'h0);
        check("rd_resp_penable", 32'(penable), 32'h0);
        step();
        check("rd_idle_cmd_ready", 32'(cmd_ready), 32'h1);
        check("rd_idle_rsp_valid", 32'(rsp_valid), 32'h0);

        // Write to slave 2 with three wait states, then ten cycles of response backpressure
        pready       = 3'b011;
        pslverr      = 3'b000;
        slv_rdata[2] = 32'hAAAA5555;
        rsp_ready    = 1'b0;
        issue(1'b1, 32'h0000_2000, 32'h12345678, 4'b0011, 3'b001);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("wr_psel_%0d", i), 32'(psel), 32'h4);
            check($sformatf("wr_penable_%0d", i), 32'(penable), (i == 0) ? 32'h0 : 32'h1);
            check($sformatf("wr_pwdata_%0d", i), pwdata, 32'h12345678);
            check($sformatf("wr_pstrb_%0d", i), 32'(pstrb), 32'h3);
            check($sformatf("wr_paddr_%0d", i), paddr, 32'h2000);
            check($sformatf("wr_rsp_valid_%0d", i), 32'(rsp_valid), 32'h0);
            if (i == 4) pready[2] = 1'b1;
            step();
        end
        check("wr_pwrite", 32'(pwrite), 32'h1);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp_rsp_valid_%0d", i), 32'(rsp_valid), 32'h1);
            check($sformatf("bp_rsp_err_%0d", i), 32'(rsp_err), 32'h0);
            check($sformatf("bp_rsp_rdata_%0d", i), rsp_rdata, 32'h0);
            check($sformatf("bp_cmd_ready_%0d", i), 32'(cmd_ready), 32'h0);
            check($sformatf("bp_psel_%0d", i), 32'(psel), 32'h0);
            step();
        end
        check("bp_hold_pwdata", pwdata, 32'h12345678);
        rsp_ready = 1'b1;
        step();
        check("wr_idle_cmd_ready", 32'(cmd_ready), 32'h1);
        check("wr_idle_paddr", paddr, 32'h2000);
        check("wr_idle_pstrb", 32'(pstrb), 32'h3);

        // Decode error: index 3 is beyond the three mapped slaves
        issue(1'b0, 32'h0000_3000, 32'h0, 4'h0, 3'b000);
        check("dec_rsp_valid", 32'(rsp_valid), 32'h1);
        check("dec_rsp_err", 32'(rsp_err), 32'h1);
        check("dec_rsp_rdata", rsp_rdata, 32'h0);
        check("dec_psel", 32'(psel), 32'h0);
        check("dec_penable", 32'(penable), 32'h0);
        check("dec_paddr_kept", paddr, 32'h2000);
        step();
        check("dec_idle_cmd_ready", 32'(cmd_ready), 32'h1);

        // Timeout: slave 1 never ready, exactly 16 ACCESS cycles
        pready       = 3'b000;
        slv_rdata[1] = 32'h5A5A5A5A;
        issue(1'b0, 32'h0000_1008, 32'h0, 4'h0, 3'b000);
        check("to_setup_psel", 32'(psel), 32'h2);
        for (int i = 0; i < TIMEOUT; i++) begin
            step();
            check($sformatf("to_access_psel_%0d", i), 32'(psel), 32'h2);
            check($sformatf("to_access_penable_%0d", i), 32'(penable), 32'h1);
        end
        step();
        check("to_resp_psel", 32'(psel), 32'h0);
        check("to_resp_penable", 32'(penable), 32'h0);
        check("to_resp_valid", 32'(rsp_valid), 32'h1);
        check("to_resp_err", 32'(rsp_err), 32'h1);
        check("to_resp_rdata", rsp_rdata, 32'h0);
        step();

        // pready arriving on the last allowed ACCESS cycle wins over the timeout
        slv_rdata[0] = 32'h0BADF00D;
        issue(1'b0, 32'h0000_0010, 32'h0, 4'h0, 3'b000);
        for (int i = 0; i < TIMEOUT; i++) begin
            step();
            if (i == TIMEOUT - 1) pready[0] = 1'b1;
        end
        step();
        check("prio_rsp_valid", 32'(rsp_valid), 32'h1);
        check("prio_rsp_err", 32'(rsp_err), 32'h0);
        check("prio_rsp_rdata", rsp_rdata, 32'h0BADF00D);
        step();

        // Slave error on a read still returns the slave's data
        pready       = 3'b010;
        pslverr      = 3'b010;
        slv_rdata[1] = 32'hCAFEF00D;
        issue(1'b0, 32'h0000_1000, 32'h0, 4'h0, 3'b100);
        step();
        step();
        check("slverr_rsp_valid", 32'(rsp_valid), 32'h1);
        check("slverr_rsp_err", 32'(rsp_err), 32'h1);
        check("slverr_rsp_rdata", rsp_rdata, 32'hCAFEF00D);
        step();
        check("rd_after_pwdata", pwdata, 32'h0);
        check("rd_after_pprot", 32'(pprot), 32'h4);

        // Reset while in ACCESS
        pready  = 3'b000;
        pslverr = 3'b000;
        issue(1'b0, 32'h0000_0020, 32'h0, 4'h0, 3'b000);
        step();
        check("mid_access_penable", 32'(penable), 32'h1);
        rst = 1'b1;
        step();
        check("mid_rst_psel", 32'(psel), 32'h0);
        check("mid_rst_penable", 32'(penable), 32'h0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'h0);
        check("mid_rst_paddr", paddr, 32'h0);
        rst = 1'b0;
        step();
        check("mid_rst_release_cmd_ready", 32'(cmd_ready), 32'h1);
        check("mid_rst_release_rsp_valid", 32'(rsp_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
